mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-master (CPU / RAS) arbiter for a single synchronous memory port.
// Optional MEM_ARB_STATS_EN adds saturating stall/hold counters.
module mem_port_arbiter #(
    parameter int          STARVE_LIMIT = 8,
    parameter logic [31:0] MEM_BASE     = 32'h2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [3:0]  cpu_be,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_din,
    output logic        cpu_hold,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_dout,
    input  logic        ras_req,
    input  logic        ras_we,
    input  logic [31:0] ras_addr,
    input  logic [31:0] ras_din,
    output logic        ras_gnt,
    output logic        ras_rvalid,
    output logic [31:0] ras_dout,
    output logic        mem_en,
    output logic [3:0]  mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0] ras_stall_cnt,
    output logic [15:0] cpu_hold_cnt
`endif
);

    localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [0:0] {
        CPU_PRI   = 1'b0,
        RAS_FORCE = 1'b1
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_starve;
    logic            r_rd_valid;
    logic            r_rd_owner;   // 1 = outstanding read belongs to RAS

    logic            w_force;
    logic            w_cpu_gnt;
    logic            w_ras_gnt;
    logic [CW-1:0]   w_starve_nxt;
    logic            w_to_force;

    // Grants are combinational; nothing is granted while reset is asserted.
    assign w_force   = (r_state == RAS_FORCE) && ras_req && !rst;
    assign w_cpu_gnt = !rst && cpu_req && !w_force;
    assign w_ras_gnt = !rst && ras_req && (w_force || !cpu_req);
    assign cpu_hold  = cpu_req && !w_cpu_gnt;
    assign ras_gnt   = w_ras_gnt;

    // Next starvation count, saturating at the limit.
    always_comb begin
        w_starve_nxt = {CW{1'b0}};
        if (ras_req && !w_ras_gnt) begin
            if (r_starve == LIMIT) begin
                w_starve_nxt = r_starve;
            end else begin
                w_starve_nxt = r_starve + CW'(1);
            end
        end else begin
            w_starve_nxt = {CW{1'b0}};
        end
    end

    // Force on the cycle whose denial brings the count up to the limit.
    assign w_to_force = (STARVE_LIMIT > 0) && (r_state == CPU_PRI) &&
                        (w_starve_nxt == LIMIT) && ras_req && !w_ras_gnt;

    // Arbiter state, starvation counter and read-return owner tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= CPU_PRI;
            r_starve   <= {CW{1'b0}};
            r_rd_valid <= 1'b0;
            r_rd_owner <= 1'b0;
        end else begin
            r_starve   <= w_starve_nxt;
            r_rd_valid <= (w_cpu_gnt && !cpu_we) || (w_ras_gnt && !ras_we);
            r_rd_owner <= w_ras_gnt;
            case (r_state)
                CPU_PRI: begin
                    if (w_to_force) begin
                        r_state <= RAS_FORCE;
                    end else begin
                        r_state <= CPU_PRI;
                    end
                end
                RAS_FORCE: r_state <= CPU_PRI;
                default:   r_state <= CPU_PRI;
            endcase
        end
    end

    // Memory port drive from whichever master holds the grant.
    always_comb begin
        mem_en   = 1'b0;
        mem_wen  = 4'b0000;
        mem_addr = 32'h0000_0000;
        mem_din  = 32'h0000_0000;
        if (w_cpu_gnt) begin
            mem_en   = 1'b1;
            mem_wen  = cpu_we ? cpu_be : 4'b0000;
            mem_addr = cpu_addr - MEM_BASE;
            mem_din  = cpu_din;
        end else if (w_ras_gnt) begin
            mem_en   = 1'b1;
            mem_wen  = ras_we ? 4'b1111 : 4'b0000;
            mem_addr = ras_addr - MEM_BASE;
            mem_din  = ras_din;
        end else begin
            mem_en   = 1'b0;
        end
    end

    // Route returning read data to the tagged owner only.
    always_comb begin
        cpu_rvalid = 1'b0;
        ras_rvalid = 1'b0;
        cpu_dout   = 32'h0000_0000;
        ras_dout   = 32'h0000_0000;
        if (!rst && r_rd_valid) begin
            if (r_rd_owner) begin
                ras_rvalid = 1'b1;
                ras_dout   = mem_dout;
            end else begin
                cpu_rvalid = 1'b1;
                cpu_dout   = mem_dout;
            end
        end else begin
            cpu_rvalid = 1'b0;
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [15:0] r_ras_stall_cnt;
    logic [15:0] r_cpu_hold_cnt;

    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ras_stall_cnt <= 16'h0000;
            r_cpu_hold_cnt  <= 16'h0000;
        end else begin
            if (ras_req && !w_ras_gnt && (r_ras_stall_cnt != 16'hFFFF)) begin
                r_ras_stall_cnt <= r_ras_stall_cnt + 16'h0001;
            end
            if (cpu_hold && (r_cpu_hold_cnt != 16'hFFFF)) begin
                r_cpu_hold_cnt <= r_cpu_hold_cnt + 16'h0001;
            end
        end
    end

    assign ras_stall_cnt = r_ras_stall_cnt;
    assign cpu_hold_cnt  = r_cpu_hold_cnt;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table plus starvation/reset sequences.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [3:0]  cpu_be;
    logic [31:0] cpu_addr, cpu_din;
    logic        cpu_hold, cpu_rvalid;
    logic [31:0] cpu_dout;
    logic        ras_req, ras_we;
    logic [31:0] ras_addr, ras_din;
    logic        ras_gnt, ras_rvalid;
    logic [31:0] ras_dout;
    logic        mem_en;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr, mem_din, mem_dout;
`ifdef MEM_ARB_STATS_EN
    logic [15:0] ras_stall_cnt, cpu_hold_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be),
        .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_hold(cpu_hold), .cpu_rvalid(cpu_rvalid), .cpu_dout(cpu_dout),
        .ras_req(ras_req), .ras_we(ras_we), .ras_addr(ras_addr), .ras_din(ras_din),
        .ras_gnt(ras_gnt), .ras_rvalid(ras_rvalid), .ras_dout(ras_dout),
        .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout)
`ifdef MEM_ARB_STATS_EN
        , .ras_stall_cnt(ras_stall_cnt), .cpu_hold_cnt(cpu_hold_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        cpu_req, cpu_we;
        logic [3:0]  cpu_be;
        logic [31:0] cpu_addr, cpu_din;
        logic        ras_req, ras_we;
        logic [31:0] ras_addr, ras_din, mem_dout;
        logic        e_hold, e_gnt, e_en;
        logic [3:0]  e_wen;
        logic [31:0] e_addr, e_din;
        logic        e_crv;
        logic [31:0] e_cdo;
        logic        e_rrv;
        logic [31:0] e_rdo;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive at the falling edge, leave outputs settled for checking.
    task automatic step(input logic rs,
                        input logic cr, input logic cw, input logic [3:0] cbe,
                        input logic [31:0] ca, input logic [31:0] cd,
                        input logic rr, input logic rw,
                        input logic [31:0] ra, input logic [31:0] rd,
                        input logic [31:0] md);
        @(negedge clk);
        rst = rs;
        cpu_req = cr; cpu_we = cw; cpu_be = cbe; cpu_addr = ca; cpu_din = cd;
        ras_req = rr; ras_we = rw; ras_addr = ra; ras_din = rd;
        mem_dout = md;
        #1;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic both(input logic rs, input logic [31:0] md);
        step(rs, 1'b1, 1'b0, 4'hF, 32'h0000_2000, 32'h0, 1'b1, 1'b0, 32'h0000_2400, 32'h0, md);
    endtask

    initial begin
        rst = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_be = 4'h0; cpu_addr = 32'h0; cpu_din = 32'h0;
        ras_req = 1'b0; ras_we = 1'b0; ras_addr = 32'h0; ras_din = 32'h0;
        mem_dout = 32'h0;

        vecs[0]  = '{1'b0,1'b0,4'h0,32'h0,32'h0,         1'b0,1'b0,32'h0,32'h0,         32'h0BAD0000,
                     1'b0,1'b0,1'b0,4'h0,32'h0,32'h0,          1'b0,32'h0,1'b0,32'h0};
        vecs[1]  = '{1'b1,1'b0,4'hF,32'h2010,32'h0,      1'b0,1'b0,32'h0,32'h0,         32'h0BAD0001,
                     1'b0,1'b0,1'b1,4'h0,32'h10,32'h0,         1'b0,32'h0,1'b0,32'h0};
        vecs[2]  = '{1'b0,1'b0,4'h0,32'h0,32'h0,         1'b0,1'b0,32'h0,32'h0,         32'hA5A50001,
                     1'b0,1'b0,1'b0,4'h0,32'h0,32'h0,          1'b1,32'hA5A50001,1'b0,32'h0};
        vecs[3]  = '{1'b0,1'b0,4'h0,32'h0,32'h0,         1'b1,1'b1,32'h2100,32'hDEADBEEF, 32'h0BAD0003,
                     1'b0,1'b1,1'b1,4'hF,32'h100,32'hDEADBEEF, 1'b0,32'h0,1'b0,32'h0};
        vecs[4]  = '{1'b1,1'b0,4'hF,32'h2020,32'h0,      1'b0,1'b0,32'h0,32'h0,         32'h0BAD0004,
                     1'b0,1'b0,1'b1,4'h0,32'h20,32'h0,         1'b0,32'h0,1'b0,32'h0};
        vecs[5]  = '{1'b0,1'b0,4'h0,32'h0,32'h0,         1'b1,1'b0,32'h2200,32'h0,      32'h11111111,
                     1'b0,1'b1,1'b1,4'h0,32'h200,32'h0,        1'b1,32'h11111111,1'b0,32'h0};
        vecs[6]  = '{1'b1,1'b0,4'hF,32'h2030,32'h0,      1'b0,1'b0,32'h0,32'h0,         32'h22222222,
                     1'b0,1'b0,1'b1,4'h0,32'h30,32'h0,         1'b0,32'h0,1'b1,32'h22222222};
        vecs[7]  = '{1'b1,1'b1,4'h5,32'h2040,32'hCAFEF00D, 1'b0,1'b0,32'h0,32'h0,       32'h33333333,
                     1'b0,1'b0,1'b1,4'h5,32'h40,32'hCAFEF00D,  1'b1,32'h33333333,1'b0,32'h0};
        vecs[8]  = '{1'b1,1'b1,4'h3,32'h2050,32'h1,      1'b1,1'b0,32'h2300,32'h0,      32'h0BAD0008,
                     1'b0,1'b0,1'b1,4'h3,32'h50,32'h1,         1'b0,32'h0,1'b0,32'h0};
        vecs[9]  = '{1'b0,1'b0,4'h0,32'h0,32'h0,         1'b0,1'b0,32'h0,32'h0,         32'h44444444,
                     1'b0,1'b0,1'b0,4'h0,32'h0,32'h0,          1'b0,32'h0,1'b0,32'h0};
        vecs[10] = '{1'b1,1'b0,4'hF,32'h1000,32'h0,      1'b0,1'b0,32'h0,32'h0,         32'h0BAD000A,
                     1'b0,1'b0,1'b1,4'h0,32'hFFFFF000,32'h0,   1'b0,32'h0,1'b0,32'h0};
        vecs[11] = '{1'b0,1'b0,4'h0,32'h0,32'h0,         1'b0,1'b0,32'h0,32'h0,         32'h55555555,
                     1'b0,1'b0,1'b0,4'h0,32'h0,32'h0,          1'b1,32'h55555555,1'b0,32'h0};
        vecs[12] = '{1'b0,1'b0,4'h0,32'h0,32'h0,         1'b1,1'b0,32'h2000,32'h0,      32'h0BAD000C,
                     1'b0,1'b1,1'b1,4'h0,32'h0,32'h0,          1'b0,32'h0,1'b0,32'h0};
        vecs[13] = '{1'b0,1'b0,4'h0,32'h0,32'h0,         1'b0,1'b0,32'h0,32'h0,         32'h66666666,
                     1'b0,1'b0,1'b0,4'h0,32'h0,32'h0,          1'b0,32'h0,1'b1,32'h66666666};

        do_reset();
        chk("rst_cpu_rvalid", {31'h0, cpu_rvalid}, 32'h0);
        chk("rst_ras_rvalid", {31'h0, ras_rvalid}, 32'h0);
        chk("rst_mem_en",     {31'h0, mem_en},     32'h0);

        for (int i = 0; i < 14; i++) begin
            step(1'b0, vecs[i].cpu_req, vecs[i].cpu_we, vecs[i].cpu_be, vecs[i].cpu_addr,
                 vecs[i].cpu_din, vecs[i].ras_req, vecs[i].ras_we, vecs[i].ras_addr,
                 vecs[i].ras_din, vecs[i].mem_dout);
            chk($sformatf("v%0d_cpu_hold", i),   {31'h0, cpu_hold},   {31'h0, vecs[i].e_hold});
            chk($sformatf("v%0d_ras_gnt", i),    {31'h0, ras_gnt},    {31'h0, vecs[i].e_gnt});
            chk($sformatf("v%0d_mem_en", i),     {31'h0, mem_en},     {31'h0, vecs[i].e_en});
            chk($sformatf("v%0d_mem_wen", i),    {28'h0, mem_wen},    {28'h0, vecs[i].e_wen});
            chk($sformatf("v%0d_mem_addr", i),   mem_addr,            vecs[i].e_addr);
            chk($sformatf("v%0d_mem_din", i),    mem_din,             vecs[i].e_din);
            chk($sformatf("v%0d_cpu_rvalid", i), {31'h0, cpu_rvalid}, {31'h0, vecs[i].e_crv});
            chk($sformatf("v%0d_cpu_dout", i),   cpu_dout,            vecs[i].e_cdo);
            chk($sformatf("v%0d_ras_rvalid", i), {31'h0, ras_rvalid}, {31'h0, vecs[i].e_rrv});
            chk($sformatf("v%0d_ras_dout", i),   ras_dout,            vecs[i].e_rdo);
        end

        // Starvation: 8 denials, one forced RAS grant, then a fresh 8-cycle window.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            both(1'b0, 32'h7000_0000 + i);
            chk($sformatf("st_deny%0d_gnt", i),  {31'h0, ras_gnt},  32'h0);
            chk($sformatf("st_deny%0d_hold", i), {31'h0, cpu_hold}, 32'h0);
        end
        both(1'b0, 32'h7000_0008);
        chk("st_force_gnt",    {31'h0, ras_gnt},    32'h1);
        chk("st_force_hold",   {31'h0, cpu_hold},   32'h1);
        chk("st_force_addr",   mem_addr,            32'h400);
        chk("st_force_crv",    {31'h0, cpu_rvalid}, 32'h1);
        both(1'b0, 32'h7000_0009);
        chk("st_resume_gnt",   {31'h0, ras_gnt},    32'h0);
        chk("st_resume_hold",  {31'h0, cpu_hold},   32'h0);
        chk("st_resume_rrv",   {31'h0, ras_rvalid}, 32'h1);
        chk("st_resume_rdo",   ras_dout,            32'h7000_0009);
        chk("st_resume_cdo",   cpu_dout,            32'h0);
        for (int i = 0; i < 7; i++) begin
            both(1'b0, 32'h0);
            chk($sformatf("st_redeny%0d_gnt", i), {31'h0, ras_gnt}, 32'h0);
        end
        both(1'b0, 32'h0);
        chk("st_reforce_gnt",  {31'h0, ras_gnt},    32'h1);

        // RAS drops its request in the forced cycle: CPU is served normally.
        do_reset();
        for (int i = 0; i < 8; i++) both(1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 4'hF, 32'h0000_2000, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        chk("drop_hold",       {31'h0, cpu_hold},   32'h0);
        chk("drop_gnt",        {31'h0, ras_gnt},    32'h0);
        chk("drop_en",         {31'h0, mem_en},     32'h1);
        both(1'b0, 32'h0);
        chk("drop_after_gnt",  {31'h0, ras_gnt},    32'h0);

        // Reset in the forced cycle abandons the forced grant.
        do_reset();
        for (int i = 0; i < 8; i++) both(1'b0, 32'h0);
        both(1'b1, 32'h0BAD_BEEF);
        chk("frst_crv",        {31'h0, cpu_rvalid}, 32'h0);
        chk("frst_cdo",        cpu_dout,            32'h0);
        chk("frst_gnt",        {31'h0, ras_gnt},    32'h0);
        both(1'b0, 32'h0BAD_BEEF);
        chk("frst_post_gnt",   {31'h0, ras_gnt},    32'h0);
        chk("frst_post_hold",  {31'h0, cpu_hold},   32'h0);
        chk("frst_post_en",    {31'h0, mem_en},     32'h1);
        chk("frst_post_crv",   {31'h0, cpu_rvalid}, 32'h0);
`ifdef MEM_ARB_STATS_EN
        chk("frst_stall_cnt",  {16'h0, ras_stall_cnt}, 32'h0);
        chk("frst_hold_cnt",   {16'h0, cpu_hold_cnt},  32'h0);
`endif
        both(1'b0, 32'h0);
        chk("frst_post2_gnt",  {31'h0, ras_gnt},    32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
